// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S bus-master transmitter for the WM8731 DAC
// One-frame holding register in front of a left/right frame register shifted out MSB first.
module i2s_dac_tx #(
  parameter int WIDTH_DATA = 16,
  parameter int SLOT_BITS  = 32,
  parameter int HALF_DIV   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WIDTH_DATA-1:0] sample_l_i,
  input  logic [WIDTH_DATA-1:0] sample_r_i,
  output logic                  bclk_o,
  output logic                  daclrck_o,
  output logic                  dacdat_o,
  output logic                  underrun_o
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int P_W   = $clog2(SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF_DIV - 1);
  localparam logic [P_W-1:0]   P_LAST     = P_W'(SLOT_BITS - 1);
  localparam logic [P_W:0]     P_DATA_END = (P_W+1)'(WIDTH_DATA);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [P_W-1:0]        p_cnt;
  logic                  first_fall;
  logic                  hold_full;
  logic [WIDTH_DATA-1:0] hold_l;
  logic [WIDTH_DATA-1:0] hold_r;
  logic [WIDTH_DATA-1:0] frame_l;
  logic [WIDTH_DATA-1:0] frame_r;

  logic                  accept;
  logic                  fall;
  logic                  left_start;
  logic                  slot_end;
  logic                  dat_next;
  logic [P_W-1:0]        p_inc;
  logic [WIDTH_DATA-1:0] slot_word;
  logic [WIDTH_DATA-1:0] word_sh;

  assign ready_o = ~hold_full;
  assign accept  = valid_i & ~hold_full;
  assign fall    = (state != ST_IDLE) && (div_cnt == DIV_LAST) && bclk_o;

  // The first fall after leaving IDLE is forced to behave as a left-start.
  assign left_start = fall && (first_fall || ((state == ST_RIGHT) && (p_cnt == P_LAST)));
  assign slot_end   = fall && !left_start && (p_cnt == P_LAST);
  assign p_inc      = p_cnt + 1'b1;

  // Bit for position p is word[WIDTH_DATA-p]; shifting by p-1 brings it to the MSB.
  always_comb begin
    slot_word = (state == ST_RIGHT) ? frame_r : frame_l;
    word_sh   = slot_word << p_cnt;
    dat_next  = ({1'b0, p_inc} <= P_DATA_END) && word_sh[WIDTH_DATA-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      p_cnt      <= '0;
      first_fall <= 1'b0;
      bclk_o     <= 1'b0;
      daclrck_o  <= 1'b1;
      dacdat_o   <= 1'b0;
      underrun_o <= 1'b0;
      hold_full  <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      frame_l    <= '0;
      frame_r    <= '0;
    end else begin
      underrun_o <= 1'b0;

      if (accept) begin
        hold_full <= 1'b1;
        hold_l    <= sample_l_i;
        hold_r    <= sample_r_i;
      end else if (left_start && enable_i && hold_full) begin
        hold_full <= 1'b0;
      end

      if (state == ST_IDLE) begin
        if (enable_i) begin
          // The enable cycle itself counts as divider phase 0.
          state      <= ST_LEFT;
          div_cnt    <= DIV_W'(1);
          p_cnt      <= '0;
          first_fall <= 1'b1;
        end
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk_o  <= ~bclk_o;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end

        if (left_start) begin
          first_fall <= 1'b0;
          p_cnt      <= '0;
          dacdat_o   <= 1'b0;
          if (!enable_i) begin
            state     <= ST_IDLE;
            daclrck_o <= 1'b1;
          end else begin
            state     <= ST_LEFT;
            daclrck_o <= 1'b0;
            if (hold_full) begin
              frame_l <= hold_l;
              frame_r <= hold_r;
            end else begin
              frame_l    <= '0;
              frame_r    <= '0;
              underrun_o <= 1'b1;
            end
          end
        end else if (slot_end) begin
          state     <= ST_RIGHT;
          daclrck_o <= 1'b1;
          p_cnt     <= '0;
          dacdat_o  <= 1'b0;
        end else if (fall) begin
          p_cnt    <= p_inc;
          dacdat_o <= dat_next;
        end
      end
    end
  end

endmodule
